// File: rtl/cdb_mul_unit_pkg.sv
// Shared definitions for common data bus (CDB) producers: slot geometry,
// slot indices and the slot packing helper used by every producer.
package cdb_mul_unit_pkg;

    // Whole CDB is four 36-bit slots plus spare bits owned by the ROB side.
    localparam int CDB_SLOT_W   = 36;
    localparam int CDB_W        = 148;
    localparam int ROB_TAG_W    = 3;
    localparam int SLOT_VALUE_W = 32;

    // Field offsets inside one slot: [35:4] value, [3] valid, [2:0] tag.
    localparam int VALID_BIT = 3;
    localparam int TAG_LSB   = 0;
    localparam int VALUE_LSB = 4;

    // Position of each producer's slot on the CDB.
    typedef enum logic [1:0] {
        DP  = 2'd0,
        MEM = 2'd1,
        MUL = 2'd2,
        FP  = 2'd3
    } cdb_slot_e;

    // Build a slot; value and tag are forced to zero when valid is low so
    // the ROB can never latch a stale tag from an idle slot.
    function automatic logic [CDB_SLOT_W-1:0] cdb_slot_pack(
        input logic [SLOT_VALUE_W-1:0] value,
        input logic                    valid,
        input logic [ROB_TAG_W-1:0]    tag
    );
        logic [CDB_SLOT_W-1:0] slot;
        slot = '0;
        if (valid) begin
            slot[VALUE_LSB +: SLOT_VALUE_W] = value;
            slot[VALID_BIT]                 = 1'b1;
            slot[TAG_LSB +: ROB_TAG_W]      = tag;
        end
        return slot;
    endfunction

endpackage

// File: rtl/cdb_mul_unit_if.sv
// Issue-side and CDB-side signals of the multiply unit.
//
// Handshake: there is no ready anywhere. Issue=1 means the operands, tag and
// mode bits are valid this cycle and are consumed at the rising edge
// unconditionally. CDB_MUL[3]=1 means value/tag are valid for exactly this
// cycle and the ROB consumes them unconditionally.
interface cdb_mul_unit_if;
    import cdb_mul_unit_pkg::*;

    logic                    Issue;
    logic [SLOT_VALUE_W-1:0] OpA;
    logic [SLOT_VALUE_W-1:0] OpB;
    logic [ROB_TAG_W-1:0]    Tag;
    logic                    SignedOp;
    logic                    High;
    logic                    Flush;
    logic [CDB_SLOT_W-1:0]   CDB_MUL;
    logic                    Busy;
    logic [3:0]              InFlight;

    // Issue stage / ROB side.
    modport master (
        output Issue, OpA, OpB, Tag, SignedOp, High, Flush,
        input  CDB_MUL, Busy, InFlight
    );

    // Multiply unit side.
    modport slave (
        input  Issue, OpA, OpB, Tag, SignedOp, High, Flush,
        output CDB_MUL, Busy, InFlight
    );

endinterface

// File: rtl/cdb_mul_unit_mul_pipe_stage.sv
// One stage of the multiply pipeline: valid/tag/data register. The valid bit
// clears synchronously on reset or flush; tag/data carry no reset because the
// slot packer hides them whenever valid is low.
module cdb_mul_unit_mul_pipe_stage #(
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] data
);

    // Valid bit: reset and flush both kill whatever this stage holds or receives.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            valid <= 1'b0;
        end else begin
            valid <= in_valid;
        end
    end

    // Payload only moves with a valid op, which keeps idle stages quiet.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            tag  <= in_tag;
            data <= in_data;
        end
    end

endmodule

// File: rtl/cdb_mul_unit.sv
// Fully pipelined 32x32 multiply unit driving the MUL slot of the CDB.
// The whole product is formed in front of stage 1 and only the selected half
// is registered; the remaining LATENCY-1 stages just delay valid/tag/result.
module cdb_mul_unit
    import cdb_mul_unit_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int TAG_W   = ROB_TAG_W,
    parameter int DATA_W  = SLOT_VALUE_W
) (
    input  logic           CLK,
    input  logic           Reset_n,
    cdb_mul_unit_if.slave  bus
);

    logic [2*DATA_W-1:0] op_a_ext;
    logic [2*DATA_W-1:0] op_b_ext;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]   issue_data;

    logic              stage_valid [LATENCY];
    logic [TAG_W-1:0]  stage_tag   [LATENCY];
    logic [DATA_W-1:0] stage_data  [LATENCY];

    logic [3:0] in_flight;

    // Extend both operands to the full product width, then pick one half.
    always_comb begin
        op_a_ext = '0;
        op_b_ext = '0;
        if (bus.SignedOp) begin
            op_a_ext = {{DATA_W{bus.OpA[DATA_W-1]}}, bus.OpA};
            op_b_ext = {{DATA_W{bus.OpB[DATA_W-1]}}, bus.OpB};
        end else begin
            op_a_ext = {{DATA_W{1'b0}}, bus.OpA};
            op_b_ext = {{DATA_W{1'b0}}, bus.OpB};
        end
        product    = op_a_ext * op_b_ext;
        issue_data = bus.High ? product[2*DATA_W-1:DATA_W] : product[DATA_W-1:0];
    end

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        if (i == 0) begin : g_first
            cdb_mul_unit_mul_pipe_stage #(
                .TAG_W  (TAG_W),
                .DATA_W (DATA_W)
            ) u_stage (
                .clk      (CLK),
                .rst_n    (Reset_n),
                .flush    (bus.Flush),
                .in_valid (bus.Issue),
                .in_tag   (bus.Tag),
                .in_data  (issue_data),
                .valid    (stage_valid[i]),
                .tag      (stage_tag[i]),
                .data     (stage_data[i])
            );
        end else begin : g_rest
            cdb_mul_unit_mul_pipe_stage #(
                .TAG_W  (TAG_W),
                .DATA_W (DATA_W)
            ) u_stage (
                .clk      (CLK),
                .rst_n    (Reset_n),
                .flush    (bus.Flush),
                .in_valid (stage_valid[i-1]),
                .in_tag   (stage_tag[i-1]),
                .in_data  (stage_data[i-1]),
                .valid    (stage_valid[i]),
                .tag      (stage_tag[i]),
                .data     (stage_data[i])
            );
        end
    end

    // Occupancy straight from the registered valids, so it has no extra lag.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            in_flight = in_flight + {3'b000, stage_valid[i]};
        end
    end

    assign bus.InFlight = in_flight;
    assign bus.Busy     = (in_flight != 4'd0);

    // Last stage drives the slot; the packer zeroes value/tag when idle.
    assign bus.CDB_MUL = cdb_slot_pack(stage_data[LATENCY-1],
                                       stage_valid[LATENCY-1],
                                       stage_tag[LATENCY-1]);

endmodule

// File: tb/tb_cdb_mul_unit.sv
// Bench for cdb_mul_unit: two instances (LATENCY 3 and 1) driven with the same
// stimulus and compared each cycle against a schedule-based reference model.
module tb_cdb_mul_unit;

    logic clk;
    logic rst_n;

    cdb_mul_unit_if bus3 ();
    cdb_mul_unit_if bus1 ();

    cdb_mul_unit #(.LATENCY(3)) u_dut3 (
        .CLK     (clk),
        .Reset_n (rst_n),
        .bus     (bus3)
    );

    cdb_mul_unit #(.LATENCY(1)) u_dut1 (
        .CLK     (clk),
        .Reset_n (rst_n),
        .bus     (bus1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // Each issued op is scheduled to appear on the slot at a known edge.
    typedef struct {
        int          due;
        logic [35:0] slot;
    } ent_t;

    ent_t exp_q3[$];
    ent_t exp_q1[$];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int max_inf3 = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Product from plain 64-bit arithmetic on the mode rules.
    function automatic logic [31:0] ref_value(input logic [31:0] a, input logic [31:0] b,
                                              input logic s, input logic h);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            p  = 64'(sa * sb);
        end else begin
            p = {32'd0, a} * {32'd0, b};
        end
        return h ? p[63:32] : p[31:0];
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic iss, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] tg, input logic s, input logic h,
                        input logic f, input logic rn);
        ent_t        e;
        logic [35:0] exp_slot;
        logic [35:0] slot;
        @(negedge clk);
        bus3.Issue = iss; bus3.OpA = a; bus3.OpB = b; bus3.Tag = tg;
        bus3.SignedOp = s; bus3.High = h; bus3.Flush = f;
        bus1.Issue = iss; bus1.OpA = a; bus1.OpB = b; bus1.Tag = tg;
        bus1.SignedOp = s; bus1.High = h; bus1.Flush = f;
        rst_n = rn;
        @(posedge clk);
        cyc++;
        slot = {ref_value(a, b, s, h), 1'b1, tg};
        if (!rn || f) begin
            exp_q3.delete();
            exp_q1.delete();
        end else if (iss) begin
            e.slot = slot;
            e.due = cyc + 2;
            exp_q3.push_back(e);
            e.due = cyc;
            exp_q1.push_back(e);
        end
        #1;
        exp_slot = (exp_q3.size() > 0 && exp_q3[0].due == cyc) ? exp_q3[0].slot : 36'h0;
        check("cdb3", 64'(bus3.CDB_MUL), 64'(exp_slot));
        check("inflight3", 64'(bus3.InFlight), 64'(exp_q3.size()));
        check("busy3", 64'(bus3.Busy), 64'(exp_q3.size() != 0));
        if (exp_q3.size() > 0 && exp_q3[0].due == cyc) void'(exp_q3.pop_front());
        exp_slot = (exp_q1.size() > 0 && exp_q1[0].due == cyc) ? exp_q1[0].slot : 36'h0;
        check("cdb1", 64'(bus1.CDB_MUL), 64'(exp_slot));
        check("inflight1", 64'(bus1.InFlight), 64'(exp_q1.size()));
        check("busy1", 64'(bus1.Busy), 64'(exp_q1.size() != 0));
        if (exp_q1.size() > 0 && exp_q1[0].due == cyc) void'(exp_q1.pop_front());
        if (int'(bus3.InFlight) > max_inf3) max_inf3 = int'(bus3.InFlight);
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] tg,
                         input logic s, input logic h);
        step(1'b1, a, b, tg, s, h, 1'b0, 1'b1);
    endtask

    // Single op on an empty pipe with a literal expected value and timing.
    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] tg, input logic s, input logic h,
                            input logic [31:0] exp_val);
        issue(a, b, tg, s, h);
        check({name, "_lat1"}, 64'(bus1.CDB_MUL), 64'({exp_val, 1'b1, tg}));
        check({name, "_lat3_early"}, 64'(bus3.CDB_MUL), 64'(0));
        idle();
        idle();
        check({name, "_lat3"}, 64'(bus3.CDB_MUL), 64'({exp_val, 1'b1, tg}));
        idle();
        check({name, "_lat3_after"}, 64'(bus3.CDB_MUL), 64'(0));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0;
        bus3.Issue = 1'b0; bus3.OpA = '0; bus3.OpB = '0; bus3.Tag = '0;
        bus3.SignedOp = 1'b0; bus3.High = 1'b0; bus3.Flush = 1'b0;
        bus1.Issue = 1'b0; bus1.OpA = '0; bus1.OpB = '0; bus1.Tag = '0;
        bus1.SignedOp = 1'b0; bus1.High = 1'b0; bus1.Flush = 1'b0;

        // Reset state.
        repeat (3) step(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_cdb3", 64'(bus3.CDB_MUL), 64'(0));
        check("reset_inflight3", 64'(bus3.InFlight), 64'(0));
        idle();
        idle();

        // Arithmetic corners.
        directed("u_low",    32'd3,          32'd5,          3'd2, 1'b0, 1'b0, 32'd15);
        directed("s_high",   32'hFFFF_FFFE,  32'd3,          3'd5, 1'b1, 1'b1, 32'hFFFF_FFFF);
        directed("u_high",   32'hFFFF_FFFE,  32'd3,          3'd5, 1'b0, 1'b1, 32'h0000_0002);
        directed("umax_hi",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  3'd7, 1'b0, 1'b1, 32'hFFFF_FFFE);
        directed("umax_lo",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  3'd6, 1'b0, 1'b0, 32'h0000_0001);
        directed("smin_hi",  32'h8000_0000,  32'h8000_0000,  3'd1, 1'b1, 1'b1, 32'h4000_0000);

        // Streaming tags 0..7 back to back.
        max_inf3 = 0;
        for (int i = 0; i < 8; i++) begin
            issue($urandom, $urandom, 3'(i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        repeat (4) idle();
        check("stream_peak_inflight3", 64'(max_inf3), 64'(3));

        // Flush with a same-cycle issue.
        issue(32'd11, 32'd13, 3'd1, 1'b0, 1'b0);
        issue(32'd17, 32'd19, 3'd2, 1'b0, 1'b0);
        issue(32'd23, 32'd29, 3'd3, 1'b0, 1'b0);
        step(1'b1, 32'd31, 32'd37, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1);
        check("flush_inflight3", 64'(bus3.InFlight), 64'(0));
        check("flush_cdb1", 64'(bus1.CDB_MUL), 64'(0));
        repeat (3) idle();
        directed("post_flush", 32'd6, 32'd7, 3'd3, 1'b0, 1'b0, 32'd42);

        // Flush on an empty pipe.
        step(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();

        // Same tag on consecutive cycles.
        issue(32'd2, 32'd2, 3'd4, 1'b0, 1'b0);
        issue(32'd3, 32'd3, 3'd4, 1'b0, 1'b0);
        repeat (3) idle();

        // Reset with two ops in flight.
        issue(32'd100, 32'd200, 3'd5, 1'b0, 1'b0);
        issue(32'd300, 32'd400, 3'd6, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midreset_cdb3", 64'(bus3.CDB_MUL), 64'(0));
        check("midreset_busy3", 64'(bus3.Busy), 64'(0));
        repeat (4) idle();
        directed("post_reset", 32'd3, 32'd5, 3'd2, 1'b0, 1'b0, 32'd15);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), pick_operand(), pick_operand(),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 49) != 0));
        end
        repeat (4) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
